// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and data-memory wait sequencer for the 5-stage RV32I pipeline.
// Build macro HAZARD_PERF_CNT_EN adds the perf_stall/perf_flush/perf_memwait counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwen,
    input  logic        id_is_load,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
`ifdef HAZARD_PERF_CNT_EN
    output logic        mem_err,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_memwait
`else
    output logic        mem_err
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_q;
    logic [7:0] wait_cnt_q;
    logic       mem_err_q;

    // Only the EX and MEM producers are consulted; the regfile covers WB by write-before-read.
    logic [4:0] ex_rd_q;
    logic       ex_wen_q;
    logic       ex_load_q;
    logic [4:0] mem_rd_q;
    logic       mem_wen_q;

    logic       load_use;
    logic [3:0] fwd_sel;

    assign load_use = id_valid & ex_load_q & ex_wen_q & (ex_rd_q != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                       (id_use_rs2 & (id_rs2 == ex_rd_q)));

    always_comb begin
        freeze    = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN:   freeze = mem_req & ~mem_ready;
                ST_WAIT:  freeze = ~mem_ready;
                default:  freeze = 1'b1;
            endcase
            if (freeze) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ex_redirect) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_req & ~mem_ready) begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    // A completion in the same cycle as the limit still counts as success.
                    if (mem_ready) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= 8'd0;
                    end else if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_q   <= ST_ERROR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                ST_ERROR: begin
                    mem_err_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_RUN;
                    wait_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign mem_err = mem_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd_q   <= 5'd0;
            ex_wen_q  <= 1'b0;
            ex_load_q <= 1'b0;
            mem_rd_q  <= 5'd0;
            mem_wen_q <= 1'b0;
        end else if (!freeze) begin
            ex_rd_q   <= id_rd;
            ex_wen_q  <= id_valid & id_regwen & ~bubble_ex;
            ex_load_q <= id_valid & id_is_load & ~bubble_ex;
            mem_rd_q  <= ex_rd_q;
            mem_wen_q <= ex_wen_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [4:0] src_rs;
            logic       src_use;
            logic [1:0] sel_d;
            logic [1:0] sel_q;

            assign src_rs  = (gi == 0) ? id_rs1 : id_rs2;
            assign src_use = (gi == 0) ? id_use_rs1 : id_use_rs2;

            // EX is checked before MEM so the youngest producer wins.
            always_comb begin
                sel_d = 2'b00;
                if (src_use && (src_rs != 5'd0)) begin
                    if (ex_wen_q && (src_rs == ex_rd_q)) begin
                        sel_d = 2'b01;
                    end else if (mem_wen_q && (src_rs == mem_rd_q)) begin
                        sel_d = 2'b10;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sel_q <= 2'b00;
                end else if (!freeze) begin
                    sel_q <= bubble_ex ? 2'b00 : sel_d;
                end
            end

            assign fwd_sel[gi*2 +: 2] = sel_q;
        end
    endgenerate

    assign fwd_a = fwd_sel[1:0];
    assign fwd_b = fwd_sel[3:2];

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0]  perf_inc;
    logic [95:0] perf_all;

    assign perf_inc = {freeze, flush_id, stall_id & bubble_ex};

    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] cnt_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= 32'd0;
                end else if ((state_q != ST_ERROR) && perf_inc[gi]) begin
                    cnt_q <= cnt_q + 32'd1;
                end
            end

            assign perf_all[gi*32 +: 32] = cnt_q;
        end
    endgenerate

    assign perf_stall   = perf_all[31:0];
    assign perf_flush   = perf_all[63:32];
    assign perf_memwait = perf_all[95:64];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic against an instruction-queue model.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwen, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, mem_req, mem_ready;
    logic       stall_if, stall_id, bubble_ex, flush_id, freeze, mem_err;
    logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall, perf_flush, perf_memwait;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwen(id_regwen), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef HAZARD_PERF_CNT_EN
        .mem_err(mem_err), .perf_stall(perf_stall), .perf_flush(perf_flush),
        .perf_memwait(perf_memwait)
`else
        .mem_err(mem_err)
`endif
    );

    // Reference model: in-flight instructions, youngest first (index 0 = EX, 1 = MEM).
    typedef struct {
        logic [4:0] rd;
        bit         wen;
        bit         load;
    } slot_t;

    slot_t      pipe[$];
    int         mode;      // 0 running, 1 waiting on memory, 2 timed out
    int         wcnt;      // memory wait cycles counted so far
    logic [1:0] m_fwd_a, m_fwd_b;
    bit         m_err;

    int checks = 0;
    int errors = 0;

    bit obs_sif, obs_sid, obs_bub, obs_fl, obs_frz;
    int fcount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        slot_t empty;
        empty.rd = 5'd0; empty.wen = 1'b0; empty.load = 1'b0;
        pipe.delete();
        pipe.push_back(empty);
        pipe.push_back(empty);
        mode = 0; wcnt = 0; m_fwd_a = 2'b00; m_fwd_b = 2'b00; m_err = 1'b0;
    endtask

    function automatic logic [1:0] producer_sel(input bit use_r, input logic [4:0] rs);
        if (!use_r || rs == 5'd0) return 2'b00;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wen && pipe[k].rd == rs) return (k == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit wen, input bit ld);
        id_valid = v; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
        id_rd = 5'(rd); id_regwen = wen; id_is_load = ld;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model on the edge.
    task automatic cycle(input string tag);
        bit fz, lu, e_sif, e_sid, e_bub, e_fl;
        slot_t s;
        logic [1:0] na, nb;
        @(negedge clk);
        fz = 0; lu = 0; e_sif = 0; e_sid = 0; e_bub = 0; e_fl = 0;
        if (!reset) begin
            fz = (mode == 2) ? 1'b1 : (mode == 1) ? !mem_ready : (mem_req && !mem_ready);
            lu = id_valid && pipe[0].load && pipe[0].wen && pipe[0].rd != 5'd0 &&
                 ((id_use_rs1 && id_rs1 == pipe[0].rd) || (id_use_rs2 && id_rs2 == pipe[0].rd));
            if (fz) begin e_sif = 1; e_sid = 1; end
            else if (ex_redirect) begin e_fl = 1; e_bub = 1; end
            else if (lu) begin e_sif = 1; e_sid = 1; e_bub = 1; end
        end
        obs_sif = stall_if; obs_sid = stall_id; obs_bub = bubble_ex; obs_fl = flush_id; obs_frz = freeze;
        $display("[%0t] %s v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d w=%0b ld=%0b redir=%0b req=%0b rdy=%0b rst=%0b | sif=%0b sid=%0b bub=%0b fl=%0b frz=%0b fa=%0b fb=%0b err=%0b",
                 $time, tag, id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2, id_rd, id_regwen,
                 id_is_load, ex_redirect, mem_req, mem_ready, reset, stall_if, stall_id,
                 bubble_ex, flush_id, freeze, fwd_a, fwd_b, mem_err);
        check({tag, ".stall_if"},  32'(stall_if),  32'(e_sif));
        check({tag, ".stall_id"},  32'(stall_id),  32'(e_sid));
        check({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(e_bub));
        check({tag, ".flush_id"},  32'(flush_id),  32'(e_fl));
        check({tag, ".freeze"},    32'(freeze),    32'(fz));
        check({tag, ".fwd_a"},     32'(fwd_a),     32'(m_fwd_a));
        check({tag, ".fwd_b"},     32'(fwd_b),     32'(m_fwd_b));
        check({tag, ".mem_err"},   32'(mem_err),   32'(m_err));
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (!fz) begin
                na = e_bub ? 2'b00 : producer_sel(id_use_rs1, id_rs1);
                nb = e_bub ? 2'b00 : producer_sel(id_use_rs2, id_rs2);
                s.rd = id_rd;
                s.wen = id_valid && id_regwen && !e_bub;
                s.load = id_valid && id_is_load && !e_bub;
                pipe.push_front(s);
                void'(pipe.pop_back());
                m_fwd_a = na; m_fwd_b = nb;
            end
            if (mode == 0) begin
                if (fz) begin mode = 1; wcnt = 1; end
            end else if (mode == 1) begin
                if (mem_ready) begin mode = 0; wcnt = 0; end
                else if (wcnt == TO) mode = 2;
                else wcnt++;
            end
            m_err = (mode == 2);
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        model_reset();
        cycle("reset");
        check("reset.fwd_a", 32'(fwd_a), 32'd0);
        reset = 1'b0;

        // Load-use: lw x5 then add reading x5
        set_id(1, 0, 0, 0, 0, 5, 1, 1); cycle("lw_x5");
        set_id(1, 5, 1, 6, 0, 8, 1, 0); cycle("add_use");
        check("lu.stall_if", 32'(obs_sif), 32'd1);
        check("lu.bubble_ex", 32'(obs_bub), 32'd1);
        cycle("add_retry");
        check("lu.resolved", 32'(obs_sif), 32'd0);
        check("lu.fwd_a", 32'(fwd_a), 32'd2);

        // Back-to-back ALU, then the same with rd = x0
        set_id(1, 0, 0, 0, 0, 3, 1, 0); cycle("add_x3");
        set_id(1, 1, 1, 3, 1, 4, 1, 0); cycle("sub_x3");
        check("alu.nostall", 32'(obs_sif), 32'd0);
        check("alu.fwd_b", 32'(fwd_b), 32'd1);
        set_id(1, 0, 0, 0, 0, 0, 1, 0); cycle("add_x0");
        set_id(1, 1, 1, 0, 1, 4, 1, 0); cycle("sub_x0");
        check("alu_x0.fwd_b", 32'(fwd_b), 32'd0);

        // Double producer of x7: youngest wins
        set_id(1, 0, 0, 0, 0, 7, 1, 0); cycle("x7_old");
        set_id(1, 0, 0, 0, 0, 7, 1, 0); cycle("x7_new");
        set_id(1, 7, 1, 0, 0, 9, 1, 0); cycle("use_x7");
        check("dbl.fwd_a", 32'(fwd_a), 32'd1);

        // Redirect coinciding with load-use
        set_id(1, 0, 0, 0, 0, 5, 1, 1); cycle("lw_x5b");
        set_id(1, 5, 1, 0, 0, 10, 1, 0); ex_redirect = 1'b1; cycle("redir_lu");
        check("redir.flush_id", 32'(obs_fl), 32'd1);
        check("redir.bubble_ex", 32'(obs_bub), 32'd1);
        check("redir.stall_if", 32'(obs_sif), 32'd0);
        ex_redirect = 1'b0;
        set_id(1, 5, 1, 0, 0, 11, 1, 0); cycle("after_redir");
        check("redir.nostall", 32'(obs_sif), 32'd0);

        // Three memory wait cycles with a producer of x9 parked in EX
        set_id(1, 0, 0, 0, 0, 9, 1, 0); cycle("x9");
        set_id(1, 9, 1, 0, 0, 12, 1, 0); mem_req = 1'b1; mem_ready = 1'b0;
        fcount = 0;
        repeat (3) begin cycle("memwait"); fcount += int'(obs_frz); end
        mem_ready = 1'b1; cycle("memdone");
        check("wait.freeze_cycles", 32'(fcount), 32'd3);
        check("wait.done_freeze", 32'(obs_frz), 32'd0);
        check("wait.fwd_a", 32'(fwd_a), 32'd1);
        mem_req = 1'b0; mem_ready = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); cycle("run_idle");
        check("wait.back_run", 32'(obs_frz), 32'd0);

        // Completion in the same cycle the counter hits the limit
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (TO) cycle("edge_wait");
        mem_ready = 1'b1; cycle("edge_ready");
        check("edge.freeze", 32'(obs_frz), 32'd0);
        mem_req = 1'b0; mem_ready = 1'b0; cycle("edge_idle");
        check("edge.run", 32'(obs_frz), 32'd0);
        check("edge.mem_err", 32'(mem_err), 32'd0);

        // Timeout into the sticky error state, then recovery through reset
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (TO) cycle("to_wait");
        check("to.not_yet", 32'(mem_err), 32'd0);
        cycle("to_last");
        check("to.mem_err", 32'(mem_err), 32'd1);
        mem_req = 1'b0; mem_ready = 1'b1;
        repeat (2) cycle("err_hold");
        check("err.sticky", 32'(mem_err), 32'd1);
        check("err.stall_if", 32'(obs_sif), 32'd1);
        reset = 1'b1; cycle("err_reset");
        reset = 1'b0;
        check("err.cleared", 32'(mem_err), 32'd0);
        mem_ready = 1'b0; cycle("post_reset");
        check("err.run", 32'(obs_frz), 32'd0);

        // Random traffic over a small register window so hazards are frequent
        repeat (400) begin
            set_id(int'($urandom_range(0, 3)) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            ex_redirect = ($urandom_range(0, 9) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = ($urandom_range(0, 9) > 2);
            reset       = ($urandom_range(0, 99) == 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
